// File: rtl/joy_serial_reader_if.sv
// Three-wire link between the reader and the external joystick shift register.
// The reader is the master: it drives clock and load and receives serial data.
interface joy_serial_reader_if;
    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (output joy_clk, output joy_load, input joy_data);
    modport slave  (input joy_clk, input joy_load, output joy_data);
endinterface

// File: rtl/joy_serial_reader.sv
// Serial joystick/JAMMA reader: generates shift clock and load strobe, deserialises
// one frame per scan and debounces every bit into a stable active-low button vector.
module joy_serial_reader #(
    parameter int PLAYERS  = 2,
    parameter int BITS     = 12,
    parameter int LEAD     = 2,
    parameter int CLK_DIV  = 6,
    parameter int DEBOUNCE = 2
) (
    input  logic                    clk12,
    input  logic                    pll_lckd,
    input  logic                    enable,
    joy_serial_reader_if.master     joy,
    output logic [PLAYERS*BITS-1:0] joy_out,
    output logic                    frame_done,
    output logic                    changed
);

    localparam int N      = PLAYERS * BITS;
    localparam int F      = LEAD + N;
    localparam int SLOT_W = $clog2(F);
    localparam int CNT_W  = $clog2(DEBOUNCE + 1);

    localparam logic [CLK_DIV-1:0] TICK_AT   = CLK_DIV'(2 ** (CLK_DIV - 1) - 1);
    localparam logic [SLOT_W-1:0]  LAST_SLOT = SLOT_W'(F - 1);
    localparam logic [CNT_W-1:0]   CNT_TOP   = CNT_W'(DEBOUNCE - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [CLK_DIV-1:0]         div_q, div_d;
    logic [SLOT_W-1:0]          slot_q, slot_d;
    logic                       load_q, load_d;
    logic [N-1:0]               shadow_q, shadow_d;
    logic [N-1:0]               out_q, out_d;
    logic [N-1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic                       done_q, done_d;
    logic                       chg_q, chg_d;

    logic scan;
    logic tick;
    logic frame_end;

    // tick is the cycle before joy_clk rises; every slot action lands on that edge.
    assign tick      = scan && (div_q == TICK_AT);
    assign frame_end = tick && (slot_q == LAST_SLOT);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked blocks use non-blocking assignments only, so every flop samples
    // the pre-edge value of every other flop regardless of evaluation order.
    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A scan only stops at a frame boundary.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = SCAN;
            SCAN:    if (frame_end && !enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        scan = 1'b0;
        case (state_q)
            SCAN:    scan = 1'b1;
            default: scan = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: divider, slot counter, deserialiser, debouncer
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d signal gets a default before any condition, so no path
        // leaves one unassigned and no latch is inferred.
        div_d    = '0;
        slot_d   = slot_q;
        load_d   = load_q;
        shadow_d = shadow_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        done_d   = frame_end;
        chg_d    = 1'b0;

        // The divider only runs while scanning continues; leaving or entering the
        // scan holds it at zero so joy_clk stays low in IDLE.
        if (scan && (state_d == SCAN)) begin
            div_d = div_q + 1'b1;
        end

        if (tick) begin
            load_d = (slot_q != '0);
            slot_d = frame_end ? '0 : slot_q + 1'b1;
            for (int k = 0; k < N; k++) begin
                if (slot_q == SLOT_W'(LEAD + k)) begin
                    shadow_d[k] = joy.joy_data;
                end
            end
        end

        // The last data bit is captured on this same tick, hence shadow_d.
        if (frame_end) begin
            for (int i = 0; i < N; i++) begin
                if (shadow_d[i] == out_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_TOP) begin
                    out_d[i] = shadow_d[i];
                    cnt_d[i] = '0;
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            chg_d = (out_d != out_q);
        end
    end

    always_ff @(posedge clk12 or negedge pll_lckd) begin
        if (!pll_lckd) begin
            div_q    <= '0;
            slot_q   <= '0;
            load_q   <= 1'b1;
            // NOTE: shadow and debounce counters are reset like plain flops, so a
            // frame after reset never debounces against stale partial data.
            shadow_q <= '1;
            cnt_q    <= '0;
            out_q    <= '1;
            done_q   <= 1'b0;
            chg_q    <= 1'b0;
        end else begin
            div_q    <= div_d;
            slot_q   <= slot_d;
            load_q   <= load_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            done_q   <= done_d;
            chg_q    <= chg_d;
        end
    end

    assign joy.joy_clk  = div_q[CLK_DIV-1];
    assign joy.joy_load = load_q;
    assign joy_out      = out_q;
    assign frame_done   = done_q;
    assign changed      = chg_q;

endmodule

// File: tb/tb_joy_serial_reader.sv
// Self-checking bench for joy_serial_reader: a default instance and a
// 4x8-bit, LEAD=3, CLK_DIV=3, DEBOUNCE=1 instance, each fed by a serial model.
module tb_joy_serial_reader;

    localparam int N_A    = 24;
    localparam int LEAD_A = 2;
    localparam int N_B    = 32;
    localparam int LEAD_B = 3;

    localparam logic [N_A-1:0] ONES_A = '1;
    localparam logic [N_B-1:0] ONES_B = '1;

    typedef struct {
        logic [63:0] vec;
        logic        chg;
    } exp_t;

    logic clk12    = 1'b0;
    logic pll_lckd = 1'b0;
    logic en_a     = 1'b0;
    logic en_b     = 1'b0;

    logic [N_A-1:0] out_a;
    logic           done_a, chg_a;
    logic [N_B-1:0] out_b;
    logic           done_b, chg_b;

    logic [N_A-1:0] next_a = '1;
    logic [N_A-1:0] frame_a = '1;
    logic [N_B-1:0] next_b = '1;
    logic [N_B-1:0] frame_b = '1;
    int             sa_slot = 0;

    logic [63:0] m_out [2];
    int          m_run [2][64];
    exp_t        q_a [$];
    exp_t        q_b [$];

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    joy_serial_reader_if ja ();
    joy_serial_reader_if jb ();

    joy_serial_reader dut_a (
        .clk12      (clk12),
        .pll_lckd   (pll_lckd),
        .enable     (en_a),
        .joy        (ja),
        .joy_out    (out_a),
        .frame_done (done_a),
        .changed    (chg_a)
    );

    joy_serial_reader #(
        .PLAYERS  (4),
        .BITS     (8),
        .LEAD     (3),
        .CLK_DIV  (3),
        .DEBOUNCE (1)
    ) dut_b (
        .clk12      (clk12),
        .pll_lckd   (pll_lckd),
        .enable     (en_b),
        .joy        (jb),
        .joy_out    (out_b),
        .frame_done (done_b),
        .changed    (chg_b)
    );

    always #5 clk12 = ~clk12;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference debouncer: a bit flips once it has disagreed for deb frames in a row.
    function automatic exp_t model_step(input int u, input logic [63:0] pat,
                                        input int n, input int deb);
        exp_t        e;
        logic [63:0] prev;
        prev = m_out[u];
        for (int i = 0; i < n; i++) begin
            if (pat[i] != m_out[u][i]) begin
                m_run[u][i]++;
                if (m_run[u][i] >= deb) begin
                    m_out[u][i] = pat[i];
                    m_run[u][i] = 0;
                end
            end else begin
                m_run[u][i] = 0;
            end
        end
        e.vec = m_out[u] & ((64'd1 << n) - 64'd1);
        e.chg = (m_out[u] != prev);
        return e;
    endfunction

    task automatic model_reset(input int u);
        m_out[u] = '1;
        for (int i = 0; i < 64; i++) m_run[u][i] = 0;
    endtask

    // Serial shift-register models: during slot s present the bit sampled at slot s+1;
    // the frame pattern is latched at load and its expected result queued.
    initial begin : serial_a
        logic prev_clk;
        int   slot, idx;
        prev_clk = 1'b0;
        slot = 0;
        ja.joy_data = 1'b1;
        forever begin
            @(negedge clk12);
            if (!pll_lckd) begin
                slot = 0;
                prev_clk = 1'b0;
                ja.joy_data = 1'b1;
                model_reset(0);
                q_a.delete();
            end else begin
                if (ja.joy_clk && !prev_clk) begin
                    if (!ja.joy_load) begin
                        slot = 0;
                        frame_a = next_a;
                        q_a.push_back(model_step(0, 64'(frame_a), N_A, 2));
                    end else begin
                        slot++;
                    end
                    idx = slot + 1 - LEAD_A;
                    ja.joy_data = (idx >= 0 && idx < N_A) ? frame_a[idx] : 1'b1;
                end
                prev_clk = ja.joy_clk;
            end
            sa_slot = slot;
        end
    end

    initial begin : serial_b
        logic prev_clk;
        int   slot, idx;
        prev_clk = 1'b0;
        slot = 0;
        jb.joy_data = 1'b1;
        forever begin
            @(negedge clk12);
            if (!pll_lckd) begin
                slot = 0;
                prev_clk = 1'b0;
                jb.joy_data = 1'b1;
                model_reset(1);
                q_b.delete();
            end else begin
                if (jb.joy_clk && !prev_clk) begin
                    if (!jb.joy_load) begin
                        slot = 0;
                        frame_b = next_b;
                        q_b.push_back(model_step(1, 64'(frame_b), N_B, 1));
                    end else begin
                        slot++;
                    end
                    idx = slot + 1 - LEAD_B;
                    jb.joy_data = (idx >= 0 && idx < N_B) ? frame_b[idx] : 1'b1;
                end
                prev_clk = jb.joy_clk;
            end
        end
    end

    // Scoreboard: every frame_done pops one expected frame result.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk12);
            if (pll_lckd) begin
                if (done_a) begin
                    if (q_a.size() == 0) begin
                        check("a_done_without_frame", 64'(done_a), 64'd0);
                    end else begin
                        e = q_a.pop_front();
                        check("a_sb_joy_out", 64'(out_a), e.vec);
                        check("a_sb_changed", 64'(chg_a), 64'(e.chg));
                    end
                end else if (chg_a) begin
                    check("a_changed_without_done", 64'(chg_a), 64'd0);
                end
                if (done_b) begin
                    if (q_b.size() == 0) begin
                        check("b_done_without_frame", 64'(done_b), 64'd0);
                    end else begin
                        e = q_b.pop_front();
                        check("b_sb_joy_out", 64'(out_b), e.vec);
                        check("b_sb_changed", 64'(chg_b), 64'(e.chg));
                    end
                end else if (chg_b) begin
                    check("b_changed_without_done", 64'(chg_b), 64'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_done(input int u, input int frames);
        int t;
        for (int f = 0; f < frames; f++) begin
            t = 0;
            do begin
                @(negedge clk12);
                t++;
            end while (!(u == 0 ? done_a : done_b) && t < 4000);
            check(u == 0 ? "a_frame_done_seen" : "b_frame_done_seen",
                  64'(u == 0 ? done_a : done_b), 64'd1);
        end
    endtask

    task automatic frame_period(input int u, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk12);
            cyc++;
        end while (!(u == 0 ? done_a : done_b) && cyc < 4000);
    endtask

    // Starts at the edge where the scan begins; counts cycles to load fall and its width.
    task automatic measure_load(output int low_at, output int low_len);
        @(posedge clk12);
        #1;
        low_at = 0;
        while (ja.joy_load && low_at < 200) begin
            @(posedge clk12);
            #1;
            low_at++;
        end
        low_len = 0;
        while (!ja.joy_load && low_len < 200) begin
            @(posedge clk12);
            #1;
            low_len++;
        end
    endtask

    initial begin : stimulus
        int t, cyc, low_at, low_len, idle_bad, dones;
        logic [N_A-1:0] hold;

        repeat (4) @(negedge clk12);
        check("rst_joy_out", 64'(out_a), 64'(ONES_A));
        check("rst_joy_clk", 64'(ja.joy_clk), 64'd0);
        check("rst_joy_load", 64'(ja.joy_load), 64'd1);
        check("rst_frame_done", 64'(done_a), 64'd0);
        check("rst_changed", 64'(chg_a), 64'd0);

        // Scan with all buttons released.
        en_a = 1'b1;
        #2 pll_lckd = 1'b1;
        measure_load(low_at, low_len);
        check("a_first_load_delay", 64'(low_at), 64'd32);
        check("a_load_low_cycles", 64'(low_len), 64'd64);
        wait_done(0, 1);
        frame_period(0, cyc);
        check("a_frame_period", 64'(cyc), 64'd1664);
        check("a_idle_buttons", 64'(out_a), 64'(ONES_A));

        // Bit 5 held low, then released.
        next_a = ONES_A & ~(24'd1 << 5);
        wait_done(0, 1);
        check("a_bit5_frame1", 64'(out_a), 64'(ONES_A));
        wait_done(0, 1);
        check("a_bit5_frame2", 64'(out_a), 64'(ONES_A & ~(24'd1 << 5)));
        next_a = ONES_A;
        wait_done(0, 1);
        check("a_bit5_release1", 64'(out_a), 64'(ONES_A & ~(24'd1 << 5)));
        wait_done(0, 1);
        check("a_bit5_release2", 64'(out_a), 64'(ONES_A));

        // One-frame glitch on bit 23 is filtered out.
        next_a = ONES_A & ~(24'd1 << 23);
        wait_done(0, 1);
        next_a = ONES_A;
        check("a_glitch_frame", 64'(out_a), 64'(ONES_A));
        wait_done(0, 1);
        check("a_glitch_after", 64'(out_a), 64'(ONES_A));

        // enable dropped mid-frame: the frame completes, then the link idles.
        t = 0;
        while (sa_slot != 10 && t < 4000) begin
            @(negedge clk12);
            t++;
        end
        en_a = 1'b0;
        wait_done(0, 1);
        idle_bad = 0;
        dones = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk12);
            if (ja.joy_clk || !ja.joy_load) idle_bad++;
            if (done_a) dones++;
        end
        check("a_idle_pins", 64'(idle_bad), 64'd0);
        check("a_idle_no_done", 64'(dones), 64'd0);
        en_a = 1'b1;
        measure_load(low_at, low_len);
        check("a_reenable_load_delay", 64'(low_at), 64'd32);
        check("a_reenable_load_low", 64'(low_len), 64'd64);
        wait_done(0, 1);

        // Several buttons held, then reset pulsed mid-frame.
        hold = 24'hEFFFF0;
        next_a = hold;
        wait_done(0, 2);
        check("a_hold_captured", 64'(out_a), 64'(hold));
        t = 0;
        while (sa_slot != 15 && t < 4000) begin
            @(negedge clk12);
            t++;
        end
        #2 pll_lckd = 1'b0;
        #1;
        check("a_midrst_joy_out", 64'(out_a), 64'(ONES_A));
        check("a_midrst_joy_clk", 64'(ja.joy_clk), 64'd0);
        check("a_midrst_joy_load", 64'(ja.joy_load), 64'd1);
        check("a_midrst_frame_done", 64'(done_a), 64'd0);
        check("a_midrst_changed", 64'(chg_a), 64'd0);
        repeat (3) @(negedge clk12);
        #2 pll_lckd = 1'b1;
        wait_done(0, 1);
        check("a_after_rst_frame1", 64'(out_a), 64'(ONES_A));
        wait_done(0, 1);
        check("a_after_rst_frame2", 64'(out_a), 64'(hold));
        en_a = 1'b0;

        // Alternate geometry, DEBOUNCE=1.
        @(negedge clk12);
        en_b = 1'b1;
        wait_done(1, 1);
        frame_period(1, cyc);
        check("b_frame_period", 64'(cyc), 64'd280);
        check("b_idle_buttons", 64'(out_b), 64'(ONES_B));
        next_b = ONES_B & ~(32'd1 << 31);
        wait_done(1, 1);
        check("b_bit31_slot34", 64'(out_b), 64'(ONES_B & ~(32'd1 << 31)));
        next_b = ONES_B & ~(32'd1 << 23);
        wait_done(1, 1);
        check("b_glitch23_follow", 64'(out_b), 64'(ONES_B & ~(32'd1 << 23)));
        next_b = ONES_B;
        wait_done(1, 1);
        check("b_glitch23_gone", 64'(out_b), 64'(ONES_B));
        en_b = 1'b0;

        repeat (20) @(negedge clk12);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
